// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX pipeline register: control-bus bit positions and widths.
package id_ex_stage_pkg;

   localparam int CTRL_W = 11;
   localparam int REG_AW = 5;

   localparam int CTL_JUMP     = 10;
   localparam int CTL_BRANCH   = 9;
   localparam int CTL_MEM2REG  = 8;
   localparam int CTL_MEMWR    = 7;
   localparam int CTL_MEMRD    = 6;
   localparam int CTL_ALUOP_HI = 5;
   localparam int CTL_ALUOP_LO = 4;
   localparam int CTL_EXC      = 3;
   localparam int CTL_ALUSRC   = 2;
   localparam int CTL_REGWR    = 1;
   localparam int CTL_REGDST   = 0;

   // A faulting instruction may travel down the pipe but must never write the RF or memory.
   function automatic logic [CTRL_W-1:0] strip_side_effects(input logic [CTRL_W-1:0] ctrl);
      logic [CTRL_W-1:0] res;
      res = ctrl;
      if (ctrl[CTL_EXC]) begin
         res[CTL_REGWR] = 1'b0;
         res[CTL_MEMWR] = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX register; master drives ID, slave is the stage.
interface id_ex_stage_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   import id_ex_stage_pkg::*;

   logic              id_valid;
   logic [CTRL_W-1:0] id_ctrl;
   logic [REG_AW-1:0] id_rs, id_rt, id_rd;
   logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;
   logic              flush;
   logic              ex_busy;

   logic              ex_valid;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
   logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
   logic              stall_if_id;
   logic              exc_valid;
   logic [DATA_W-1:0] exc_pc;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_ctrl, id_rs, id_rt, id_rd,
             id_rdata1, id_rdata2, id_imm, id_pc4, flush, ex_busy,
      input  ex_valid, ex_ctrl, ex_rs, ex_rt, ex_rd,
             ex_rdata1, ex_rdata2, ex_imm, ex_pc4,
             stall_if_id, exc_valid, exc_pc, stall_cnt
   );

   modport slave (
      input  id_valid, id_ctrl, id_rs, id_rt, id_rd,
             id_rdata1, id_rdata2, id_imm, id_pc4, flush, ex_busy,
      output ex_valid, ex_ctrl, ex_rs, ex_rt, ex_rd,
             ex_rdata1, ex_rdata2, ex_imm, ex_pc4,
             stall_if_id, exc_valid, exc_pc, stall_cnt
   );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detection against the instruction currently held in EX.
module id_ex_stage_hazard_detect
   import id_ex_stage_pkg::*;
(
   input  logic              ex_valid,
   input  logic [CTRL_W-1:0] ex_ctrl,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              id_valid,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              flush,
   input  logic              ex_busy,
   output logic              load_use,
   output logic              stall_if_id
);

   logic uses_rt;

   // rt is a source unless it is the destination of an immediate-form op; stores and branches read it.
   assign uses_rt = !id_ctrl[CTL_ALUSRC] | id_ctrl[CTL_MEMWR] | id_ctrl[CTL_BRANCH];

   assign load_use = ex_valid & ex_ctrl[CTL_MEMRD] & (ex_rt != '0) & id_valid &
                     ((id_rs == ex_rt) | (uses_rt & (id_rt == ex_rt)));

   assign stall_if_id = ex_busy | (load_use & !flush);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble/flush/hold control, exception capture and a stall counter.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   id_ex_stage_if.slave bus
);

   logic              load_use;
   logic              stall_if_id;

   logic              ex_valid_q;
   logic [CTRL_W-1:0] ex_ctrl_q;
   logic [REG_AW-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
   logic [DATA_W-1:0] ex_rdata1_q, ex_rdata2_q, ex_imm_q, ex_pc4_q;
   logic              exc_valid_q;
   logic [DATA_W-1:0] exc_pc_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   id_ex_stage_hazard_detect u_hazard (
      .ex_valid    (ex_valid_q),
      .ex_ctrl     (ex_ctrl_q),
      .ex_rt       (ex_rt_q),
      .id_valid    (bus.id_valid),
      .id_ctrl     (bus.id_ctrl),
      .id_rs       (bus.id_rs),
      .id_rt       (bus.id_rt),
      .flush       (bus.flush),
      .ex_busy     (bus.ex_busy),
      .load_use    (load_use),
      .stall_if_id (stall_if_id)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q  <= 1'b0;
         ex_ctrl_q   <= '0;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_rd_q     <= '0;
         ex_rdata1_q <= '0;
         ex_rdata2_q <= '0;
         ex_imm_q    <= '0;
         ex_pc4_q    <= '0;
         exc_valid_q <= 1'b0;
         exc_pc_q    <= '0;
      end else if (bus.flush || (!bus.ex_busy && load_use)) begin
         ex_valid_q  <= 1'b0;
         ex_ctrl_q   <= '0;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_rd_q     <= '0;
         ex_rdata1_q <= '0;
         ex_rdata2_q <= '0;
         ex_imm_q    <= '0;
         ex_pc4_q    <= '0;
         exc_valid_q <= 1'b0;
      end else if (bus.ex_busy) begin
         exc_valid_q <= 1'b0;
      end else begin
         ex_valid_q  <= bus.id_valid;
         ex_ctrl_q   <= bus.id_valid ? strip_side_effects(bus.id_ctrl) : '0;
         ex_rs_q     <= bus.id_rs;
         ex_rt_q     <= bus.id_rt;
         ex_rd_q     <= bus.id_rd;
         ex_rdata1_q <= bus.id_rdata1;
         ex_rdata2_q <= bus.id_rdata2;
         ex_imm_q    <= bus.id_imm;
         ex_pc4_q    <= bus.id_pc4;
         exc_valid_q <= bus.id_valid & bus.id_ctrl[CTL_EXC];
         if (bus.id_valid && bus.id_ctrl[CTL_EXC])
            exc_pc_q <= bus.id_pc4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else if (stall_if_id && (stall_cnt_q != '1))
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
   end

   assign bus.ex_valid    = ex_valid_q;
   assign bus.ex_ctrl     = ex_ctrl_q;
   assign bus.ex_rs       = ex_rs_q;
   assign bus.ex_rt       = ex_rt_q;
   assign bus.ex_rd       = ex_rd_q;
   assign bus.ex_rdata1   = ex_rdata1_q;
   assign bus.ex_rdata2   = ex_rdata2_q;
   assign bus.ex_imm      = ex_imm_q;
   assign bus.ex_pc4      = ex_pc4_q;
   assign bus.stall_if_id = stall_if_id;
   assign bus.exc_valid   = exc_valid_q;
   assign bus.exc_pc      = exc_pc_q;
   assign bus.stall_cnt   = stall_cnt_q;

endmodule
